// File: rtl/bypass_tag_pipe_if.sv
// Handshake bundle between the F/D latch, hazard unit and bypass-tag pipe.
// Carries the decoded tags down the pipe plus the perf counters.
interface bypass_tag_pipe_if #(
    parameter int CNT_W = 16
);
    logic [31:0]      fd_insn;
    logic             fd_valid;
    logic             stall;
    logic             flush;
    logic [31:0]      dx_tag;
    logic [31:0]      xm_tag;
    logic [31:0]      mw_tag;
    logic [CNT_W-1:0] stall_count;
    logic [CNT_W-1:0] flush_count;

    modport master (
        output fd_insn, fd_valid, stall, flush,
        input  dx_tag, xm_tag, mw_tag, stall_count, flush_count
    );

    modport slave (
        input  fd_insn, fd_valid, stall, flush,
        output dx_tag, xm_tag, mw_tag, stall_count, flush_count
    );
endinterface

// File: rtl/bypass_tag_pipe.sv
// Decodes the F/D instruction into a bypass word and carries it down
// D/X, X/M, M/W with load-use stall, flush and saturating perf counters.
module bypass_tag_pipe #(
    parameter int CNT_W = 16
) (
    input  logic               clock,
    input  logic               reset,
    bypass_tag_pipe_if.slave   bus
);
    localparam logic [4:0] OP_R    = 5'b00000;
    localparam logic [4:0] OP_J    = 5'b00001;
    localparam logic [4:0] OP_BNE  = 5'b00010;
    localparam logic [4:0] OP_JAL  = 5'b00011;
    localparam logic [4:0] OP_JR   = 5'b00100;
    localparam logic [4:0] OP_ADDI = 5'b00101;
    localparam logic [4:0] OP_BLT  = 5'b00110;
    localparam logic [4:0] OP_SW   = 5'b00111;
    localparam logic [4:0] OP_LW   = 5'b01000;
    localparam logic [4:0] OP_SETX = 5'b10101;
    localparam logic [4:0] OP_BEX  = 5'b10110;

    logic [4:0]  w_op, w_rd, w_rs, w_rt, w_aluop;
    logic [4:0]  w_a, w_b, w_w;
    logic        w_wr, w_jr, w_lw, w_sw, w_w30;
    logic        w_rwe;
    logic [31:0] w_dec;

    logic [31:0]      r_dx, r_xm, r_mw;
    logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt;

    assign w_op    = bus.fd_insn[31:27];
    assign w_rd    = bus.fd_insn[26:22];
    assign w_rs    = bus.fd_insn[21:17];
    assign w_rt    = bus.fd_insn[16:12];
    assign w_aluop = bus.fd_insn[6:2];

    always_comb begin
        w_a   = 5'd0;
        w_b   = 5'd0;
        w_w   = 5'd0;
        w_wr  = 1'b0;
        w_jr  = 1'b0;
        w_lw  = 1'b0;
        w_sw  = 1'b0;
        w_w30 = 1'b0;
        case (w_op)
            OP_R: begin
                w_a   = w_rs;
                w_b   = w_rt;
                w_w   = w_rd;
                w_wr  = 1'b1;
                w_w30 = (w_aluop == 5'd0) || (w_aluop == 5'd1);
            end
            OP_ADDI: begin
                w_a   = w_rs;
                w_w   = w_rd;
                w_wr  = 1'b1;
                w_w30 = 1'b1;
            end
            OP_LW: begin
                w_a  = w_rs;
                w_w  = w_rd;
                w_wr = 1'b1;
                w_lw = 1'b1;
            end
            OP_SW: begin
                w_a  = w_rs;
                w_b  = w_rd;
                w_sw = 1'b1;
            end
            OP_BNE, OP_BLT: begin
                w_a = w_rd;
                w_b = w_rs;
            end
            OP_JR: begin
                w_a  = w_rd;
                w_jr = 1'b1;
            end
            OP_JAL: begin
                w_w  = 5'd31;
                w_wr = 1'b1;
            end
            OP_SETX: begin
                w_w  = 5'd30;
                w_wr = 1'b1;
            end
            OP_BEX: w_a = 5'd30;
            OP_J:   w_a = 5'd0;
            default: w_a = 5'd0;
        endcase
    end

    // Writes to $0 are architecturally dropped, so never advertise them.
    assign w_rwe = w_wr && (w_w != 5'd0);

    assign w_dec = bus.fd_valid
        ? {w_w30, w_sw, w_lw, 8'd0, 1'b1, w_jr, w_rwe, 3'd0, w_w, w_b, w_a}
        : 32'd0;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_dx <= 32'd0;
            r_xm <= 32'd0;
            r_mw <= 32'd0;
        end else if (bus.flush) begin
            r_dx <= 32'd0;
            r_xm <= r_dx;
            r_mw <= r_xm;
        end else if (bus.stall) begin
            r_xm <= 32'd0;
            r_mw <= r_xm;
        end else begin
            r_dx <= w_dec;
            r_xm <= r_dx;
            r_mw <= r_xm;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (bus.stall && !bus.flush && (r_stall_cnt != '1))
                r_stall_cnt <= r_stall_cnt + 1'b1;
            if (bus.flush && (r_flush_cnt != '1))
                r_flush_cnt <= r_flush_cnt + 1'b1;
        end
    end

    assign bus.dx_tag      = r_dx;
    assign bus.xm_tag      = r_xm;
    assign bus.mw_tag      = r_mw;
    assign bus.stall_count = r_stall_cnt;
    assign bus.flush_count = r_flush_cnt;
endmodule

// File: tb/tb_bypass_tag_pipe.sv
// Directed bench for bypass_tag_pipe: decode, pipe movement, stall/flush
// priority, saturating counters (narrow instance) and reset.
module tb_bypass_tag_pipe;
    logic clock;
    logic reset;
    int   vectors;
    int   miscompares;

    bypass_tag_pipe_if #(.CNT_W(16)) u_if  ();
    bypass_tag_pipe_if #(.CNT_W(2))  u_ifs ();

    bypass_tag_pipe #(.CNT_W(16)) u_dut (
        .clock (clock),
        .reset (reset),
        .bus   (u_if)
    );

    bypass_tag_pipe #(.CNT_W(2)) u_dut_s (
        .clock (clock),
        .reset (reset),
        .bus   (u_ifs)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [31:0] insn, input logic v,
                         input logic st, input logic fl);
        u_if.fd_insn  = insn;
        u_if.fd_valid = v;
        u_if.stall    = st;
        u_if.flush    = fl;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b1;
        drive(32'h0, 1'b0, 1'b0, 1'b0);
        u_ifs.fd_insn  = 32'h00C22000;
        u_ifs.fd_valid = 1'b0;
        u_ifs.stall    = 1'b0;
        u_ifs.flush    = 1'b0;
        step();
        check("rst_dx", u_if.dx_tag, 32'h0);
        check("rst_xm", u_if.xm_tag, 32'h0);
        check("rst_mw", u_if.mw_tag, 32'h0);
        check("rst_sc", 32'(u_if.stall_count), 32'h0);
        check("rst_fc", 32'(u_if.flush_count), 32'h0);
        reset = 1'b0;

        drive(32'h00C22000, 1'b1, 1'b0, 1'b0);
        step();
        check("add_dx", u_if.dx_tag, 32'h80140C41);
        drive(32'h41060000, 1'b1, 1'b0, 1'b0);
        step();
        check("lw_dx", u_if.dx_tag, 32'h20141003);
        check("add_xm", u_if.xm_tag, 32'h80140C41);
        drive(32'h394C0004, 1'b1, 1'b0, 1'b0);
        step();
        check("sw_dx", u_if.dx_tag, 32'h401000A6);
        check("lw_xm", u_if.xm_tag, 32'h20141003);
        check("add_mw", u_if.mw_tag, 32'h80140C41);

        drive(32'h18000010, 1'b1, 1'b1, 1'b0);
        step();
        check("stl_dx", u_if.dx_tag, 32'h401000A6);
        check("stl_xm", u_if.xm_tag, 32'h0);
        check("stl_mw", u_if.mw_tag, 32'h20141003);
        check("stl_sc", 32'(u_if.stall_count), 32'd1);

        drive(32'h18000010, 1'b1, 1'b0, 1'b0);
        step();
        check("jal_dx", u_if.dx_tag, 32'h00147C00);
        drive(32'h27C00000, 1'b1, 1'b0, 1'b0);
        step();
        check("jr_dx", u_if.dx_tag, 32'h0018001F);
        check("jal_xm", u_if.xm_tag, 32'h00147C00);

        drive(32'h00022000, 1'b1, 1'b0, 1'b0);
        step();
        check("rd0_dx", u_if.dx_tag, 32'h80100041);
        drive(32'hFFFFFFFF, 1'b0, 1'b0, 1'b0);
        step();
        check("bub_dx", u_if.dx_tag, 32'h0);

        drive(32'h00C22000, 1'b1, 1'b0, 1'b0);
        step();
        check("add2_dx", u_if.dx_tag, 32'h80140C41);
        drive(32'h41060000, 1'b1, 1'b1, 1'b1);
        step();
        check("fl_dx", u_if.dx_tag, 32'h0);
        check("fl_xm", u_if.xm_tag, 32'h80140C41);
        check("fl_fc", 32'(u_if.flush_count), 32'd1);
        check("fl_sc", 32'(u_if.stall_count), 32'd1);
        drive(32'h0, 1'b0, 1'b0, 1'b0);

        u_ifs.stall = 1'b1;
        step();
        check("sat1", 32'(u_ifs.stall_count), 32'd1);
        step();
        check("sat2", 32'(u_ifs.stall_count), 32'd2);
        step();
        check("sat3", 32'(u_ifs.stall_count), 32'd3);
        step();
        check("sat4", 32'(u_ifs.stall_count), 32'd3);
        step();
        check("sat5", 32'(u_ifs.stall_count), 32'd3);
        u_ifs.stall = 1'b0;
        u_ifs.flush = 1'b1;
        step();
        step();
        step();
        step();
        check("fsat", 32'(u_ifs.flush_count), 32'd3);

        drive(32'h00C22000, 1'b1, 1'b0, 1'b0);
        step();
        check("pre_dx", u_if.dx_tag, 32'h80140C41);
        u_if.flush  = 1'b1;
        u_if.stall  = 1'b1;
        u_ifs.stall = 1'b1;
        reset       = 1'b1;
        step();
        check("rst2_dx", u_if.dx_tag, 32'h0);
        check("rst2_xm", u_if.xm_tag, 32'h0);
        check("rst2_mw", u_if.mw_tag, 32'h0);
        check("rst2_fc", 32'(u_if.flush_count), 32'h0);
        check("rst2_ssc", 32'(u_ifs.stall_count), 32'h0);
        check("rst2_sfc", 32'(u_ifs.flush_count), 32'h0);
        reset = 1'b0;
        drive(32'h41060000, 1'b1, 1'b0, 1'b0);
        u_ifs.stall = 1'b0;
        u_ifs.flush = 1'b0;
        step();
        check("post_dx", u_if.dx_tag, 32'h20141003);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/bypass_tag_pipe.md
Name: bypass_tag_pipe

Overview:
- Producer side of the pipeline bypass-latch interface.
- Decodes the instruction leaving F/D into the 32-bit bypass-latch word consumed by the forwarding/stall unit, then carries that word down the D/X, X/M and M/W stages in lock-step with the datapath pipeline registers.
- Applies load-use stall and branch/jump flush, so the hazard logic always sees tags that match the instructions actually in flight.
- Keeps saturating stall and flush counters for performance debug.

Parameters:
- CNT_W, 16, width of the stall and flush counters.

Ports:
- clock  in  1  system clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high; clears all state
- fd_insn  in  32  instruction currently in the F/D latch
- fd_valid  in  1  fd_insn is a real instruction; 0 means a bubble
- stall  in  1  load-use stall from the forwarding unit
- flush  in  1  taken branch/jump; squashes the instruction entering D/X
- dx_tag  out  32  bypass word for the D/X stage
- xm_tag  out  32  bypass word for the X/M stage
- mw_tag  out  32  bypass word for the M/W stage
- stall_count  out  CNT_W  cycles with stall=1 and flush=0, saturating
- flush_count  out  CNT_W  cycles with flush=1, saturating

Behaviour:
- Bypass word bit layout:
  - [4:0] readregA, [9:5] readregB, [14:10] regtowrite.
  - [18] RWE, [19] jr, [20] valid (ignored by the consumer, used by verification).
  - [29] lw, [30] sw, [31] writeto30.
  - All other bits are 0. A bubble is the all-zero word.
- Instruction fields: opcode=[31:27], rd=[26:22], rs=[21:17], rt=[16:12], aluop=[6:2].
- Decode table (combinational, on fd_insn; any field not listed is 0):
  - R-type (00000): A=rs, B=rt, W=rd. writeto30=1 when aluop is 00000 (add) or 00001 (sub).
  - addi (00101): A=rs, W=rd, writeto30=1.
  - lw (01000): A=rs, W=rd, lw=1.
  - sw (00111): A=rs, B=rd, sw=1.
  - bne (00010) and blt (00110): A=rd, B=rs.
  - jr (00100): A=rd, jr=1.
  - jal (00011): W=31.
  - setx (10101): W=30.
  - bex (10110): A=30.
  - j (00001) and any unlisted opcode: no register fields set; valid=1 only.
- RWE=1 only for R-type, addi, lw, jal and setx, and only when W≠0. An R-type or addi with rd=0 has RWE=0 but keeps writeto30.
- valid = fd_valid. When fd_valid=0 the decoded word is 0.
- Update on each rising edge when reset=0, in priority order:
  - flush=1: dx_tag←0, xm_tag←dx_tag, mw_tag←xm_tag. Any concurrent stall is ignored.
  - else stall=1: dx_tag holds, xm_tag←0 (bubble), mw_tag←xm_tag.
  - else: dx_tag←decode(fd_insn), xm_tag←dx_tag, mw_tag←xm_tag.
- Latency: an instruction sampled at edge N appears on dx_tag after edge N, xm_tag after N+1, mw_tag after N+2, with one extra cycle per stall. All outputs are registered, with no combinational path from inputs to outputs.
- Counters:
  - stall_count increments on cycles where stall=1 and flush=0.
  - flush_count increments on cycles where flush=1.
  - Both saturate at 2^CNT_W−1 and never wrap.
- Reset: all three tags and both counters become 0 on the first edge with reset=1. Reset asserted mid-stall or mid-flush wins over both. The first instruction after reset appears on dx_tag after the first edge with reset=0.

Test Plan:
- Reset, then add $3,$1,$2 (0x00C22000), fd_valid=1 → dx_tag=0x80140C41 after one edge; the same word reaches xm_tag, then mw_tag, on the next two edges.
- lw $4,0($3) (0x41060000), then sw $5,4($6) (0x394C0004) → dx_tag=0x20141003 then 0x401000A6. Then assert stall for one cycle → dx_tag holds 0x401000A6, xm_tag=0, mw_tag=0x20141003, stall_count=1.
- jal 0x10 (0x18000010), then jr $31 (0x27C00000) → dx_tag=0x00147C00, then dx_tag=0x0018001F with xm_tag=0x00147C00.
- add $0,$1,$2 (0x00022000) → dx_tag=0x80100041 (RWE=0). fd_valid=0 with any fd_insn → dx_tag=0.
- flush and stall both high for one edge with dx_tag=0x80140C41 → dx_tag=0, xm_tag=0x80140C41, flush_count=1, stall_count unchanged.
- CNT_W=2: hold stall for 5 cycles → stall_count reads 1,2,3,3,3. Then reset → all outputs 0 after one edge.
